countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//  Loadable down-counter: the count-down counterpart of the up-counter. Loaded with
//  a start value, decrements on each enabled cycle, pulses `expired` on reaching the
//  terminal count. Optional auto-reload gives a periodic tick. Serves as the
//  processor's interval timer and as a wait-state/delay generator.
// PARAMETERS
//  SIZE        10   width of count, load_value and internal reload register
// PORTS
//  clk          input   1     system clock; all state changes on rising edge
//  reset        input   1     synchronous, active-high; sampled on rising edge of clk
//  enable       input   1     1 = decrement this cycle (RUN only); 0 = hold
//  load         input   1     1 = capture load_value into count and reload register
//  load_value   input   SIZE  start/reload value, unsigned
//  auto_reload  input   1     sampled at terminal edge: 1 = restart from reload value
//  count        output  SIZE  current count, registered
//  expired      output  1     one-cycle registered pulse on terminal count
//  busy         output  1     1 while in RUN
// BEHAVIOUR
//  Reset: state=IDLE, count=0, reload register=0, expired=0, busy=0.
//  Priority per edge: reset > load > decrement/hold.
//  States: IDLE (post-reset, never loaded), RUN (counting), DONE (expired, one-shot).
//  Load, any state: count<=load_value, reload<=load_value, expired<=0.
//   load_value!=0 -> RUN, busy=1; load_value==0 -> IDLE, busy=0, no pulse ever.
//  RUN, enable=0: count, state hold; expired<=0.
//  RUN, enable=1, count>1: count<=count-1; expired<=0.
//  RUN, enable=1, count==1 (terminal edge): expired<=1 for exactly that next cycle;
//   auto_reload=1 -> count<=reload, stay RUN (count never shows 0);
//   auto_reload=0 -> count<=0, ->DONE, busy<=0.
//  DONE/IDLE: count holds, expired=0, enable ignored; leave only via load.
//  Latency: N enabled cycles from load edge to expired asserted (load N, enable=1).
//   Auto-reload period = N cycles between expired pulses; N=1 -> expired every cycle.
//  Decrement is unsigned SIZE-bit, never underflows (count==0 never decremented).
//  Full-scale load (2^SIZE-1) counts the full range; no wrap-around anywhere.
//  Load on a terminal edge: load wins, no expired pulse for the aborted run.
//  Reset mid-RUN: next cycle IDLE, count=0, busy=0, pending pulse suppressed.
//  expired and busy are registered outputs, no combinational path from inputs.
// STRUCTURE
//  Shared include timer_defs.vh: state encodings TMR_IDLE=2'd0, TMR_RUN=2'd1,
//   TMR_DONE=2'd2; 2'd3 unreachable, treated as IDLE.
//  Single module: 2-bit state reg, SIZE-bit count reg, SIZE-bit reload reg,
//   expired flop; one always block for next-state, one for registers.
//  No sub-module; terminal detect (count=={{SIZE-1{1'b0}},1'b1}) stays inline.
// TESTING (SIZE=10, clk period 4 ns, stimulus driven on negedge)
//  1 reset=1 two edges, load=1, enable=1 held -> count=0, expired=0, busy=0 each cycle.
//  2 load 3, enable=1, auto_reload=0 -> count 3,2,1,0; expired=1 only on cycle
//    count hits 0; then DONE: count stays 0, busy=0, expired=0 for 5 more cycles.
//  3 load 4, auto_reload=1, enable=1 for 12 cycles -> count 4,3,2,1,4,3,2,1,...;
//    expired=1 on cycles 4, 8, 12 only; busy=1 throughout.
//  4 load 5, enable=1 to count=2, enable=0 for 5 cycles -> count stays 2, no pulse;
//    enable=1 -> 1, 0 with single expired pulse.
//  5 load 6, at count=1 with enable=1 assert load 7 -> count=7, expired=0, busy=1;
//    load 0 -> IDLE, count=0, busy=0, no pulse ever.
//  6 load 1023 run to end -> expired after exactly 1023 enabled cycles; reset at
//    count=500 -> count=0, busy=0, expired=0 next cycle.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
//   Shared definitions for the countdown timer: the state encoding. The unused
//   encoding 2'd3 is never entered and is decoded as IDLE by the timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,  // post-reset or loaded with zero; waits for a load
    TMR_RUN  = 2'd1,  // counting down
    TMR_DONE = 2'd2,  // one-shot run finished; waits for a load
    TMR_RSVD = 2'd3   // unreachable
  } tmr_state_e;

endpackage

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with terminal-count pulse and optional auto-reload.
//   Used as the interval timer and as a wait-state/delay generator.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   enable       1 = decrement this cycle while running, 0 = hold
//   load         1 = capture load_value into count and the reload register
//   load_value   start/reload value (unsigned, SIZE bits)
//   auto_reload  sampled at the terminal edge: 1 = restart from the reload value
//   count        current count (registered)
//   expired      one-cycle registered pulse on terminal count
//   busy         registered, high while running
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int SIZE = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            load,
  input  logic [SIZE-1:0] load_value,
  input  logic            auto_reload,
  output logic [SIZE-1:0] count,
  output logic            expired,
  output logic            busy
);

  localparam logic [SIZE-1:0] TERM = SIZE'(1);
  localparam logic [SIZE-1:0] ZERO = '0;

  tmr_state_e      state_q, state_d;
  logic [SIZE-1:0] count_q, count_d;
  logic [SIZE-1:0] reload_q, reload_d;
  logic            expired_q, expired_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;

    if (load) begin
      // A load aborts whatever was in progress, including a terminal edge
      // happening in the same cycle, so no pulse is produced for that run.
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != ZERO) ? TMR_RUN : TMR_IDLE;
    end else begin
      unique case (state_q)
        TMR_RUN: begin
          if (enable) begin
            if (count_q == TERM) begin
              expired_d = 1'b1;
              if (auto_reload) begin
                // Reload directly from 1 so the count never shows 0.
                count_d = reload_q;
              end else begin
                count_d = ZERO;
                state_d = TMR_DONE;
              end
            end else if (count_q != ZERO) begin
              count_d = count_q - SIZE'(1);
            end
          end
        end
        TMR_IDLE, TMR_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = TMR_IDLE;
        end
      endcase
    end

    busy_d = (state_d == TMR_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= TMR_IDLE;
      count_q   <= ZERO;
      reload_q  <= ZERO;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
    end
  end

  assign count   = count_q;
  assign expired = expired_q;
  assign busy    = busy_q;

endmodule
